// File: rtl/alu_share_arbiter.sv
// Arbitrated front end sharing one combinational ALU: grant, hold operands for SETTLE cycles, capture result.
// Build option: define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module alu_share_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 32,
  parameter int SETTLE = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [3*NREQ-1:0]         req_op,
  input  logic [WIDTH*NREQ-1:0]     req_a,
  input  logic [WIDTH*NREQ-1:0]     req_b,
  output logic [2:0]                alu_op,
  output logic [WIDTH-1:0]          alu_a,
  output logic [WIDTH-1:0]          alu_b,
  input  logic [WIDTH-1:0]          alu_y,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WIDTH-1:0]          rsp_data,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic                      rsp_err
);

  localparam int IDW  = $clog2(NREQ);
  localparam int CNTW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

  state_t            state_reg;
  logic [CNTW-1:0]   cnt_reg;
  logic [IDW-1:0]    gnt_reg;
  logic [2:0]        op_reg;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic              rsp_valid_reg;
  logic [WIDTH-1:0]  rsp_data_reg;
  logic [IDW-1:0]    rsp_id_reg;
  logic              rsp_err_reg;

  logic [2:0]        op_arr [NREQ];
  logic [WIDTH-1:0]  a_arr  [NREQ];
  logic [WIDTH-1:0]  b_arr  [NREQ];

  logic              win_found;
  logic [IDW-1:0]    win_idx;
  logic              accept;
  logic              op_illegal;

  assign accept     = (state_reg == IDLE) && win_found && rst_n;
  assign op_illegal = (op_reg > 3'd4);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign op_arr[gi]    = req_op[3*gi +: 3];
      assign a_arr[gi]     = req_a[WIDTH*gi +: WIDTH];
      assign b_arr[gi]     = req_b[WIDTH*gi +: WIDTH];
      assign req_ready[gi] = accept && (win_idx == IDW'(gi));
    end
  endgenerate

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] ptr_reg;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_reg) + k) % NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= IDW'(NREQ - 1);
    end else if (accept) begin
      ptr_reg <= win_idx;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      gnt_reg       <= '0;
      op_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg    <= op_arr[win_idx];
            a_reg     <= a_arr[win_idx];
            b_reg     <= b_arr[win_idx];
            gnt_reg   <= win_idx;
            cnt_reg   <= CNTW'(SETTLE);
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          cnt_reg <= cnt_reg - 1'b1;
          // Operands have been stable for SETTLE cycles; the ripple has settled.
          if (cnt_reg == CNTW'(1)) begin
            rsp_data_reg  <= op_illegal ? '0 : alu_y;
            rsp_id_reg    <= gnt_reg;
            rsp_err_reg   <= op_illegal;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign alu_op    = op_reg;
  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_err   = rsp_err_reg;

endmodule
